// File: rtl/spi_load_pkg.sv
// Shared types and constants for the SPI load sequencer.
// Read-FSM state encoding, page/word geometry and default sizing.
package spi_load_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StWait,
        StFinish
    } read_state_e;

    localparam int unsigned PageBytes    = 4096;
    localparam int unsigned WordBytes    = 4;
    localparam int unsigned PageWords    = PageBytes / WordBytes;
    localparam int unsigned DefMaxBurst  = 16;
    localparam int unsigned DefFifoDepth = 32;

endpackage

// File: rtl/spi_load_fifo.sv
// Single-clock FIFO between the AXI read side and the SPI request side.
// Storage is not reset; only pointers and occupancy are.
module spi_load_fifo
    import spi_load_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = DefFifoDepth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [Width-1:0]       push_data,
    input  logic                   pop,
    output logic [Width-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == (PtrW + 1)'(Depth));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/spi_load_sequencer.sv
// Streams word_cnt words from AXI memory into SPI write requests.
// The read FSM reserves FIFO space per burst; the SPI side drains the FIFO independently.
module spi_load_sequencer
    import spi_load_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 64,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_MAX_BURST  = DefMaxBurst,
    parameter int unsigned C_FIFO_DEPTH = DefFifoDepth
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    start,
    input  logic [C_ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]             word_cnt,
    input  logic [31:0]             spi_base,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [C_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                    m_axi_rlast,
    output logic                    spi_req_valid,
    input  logic                    spi_req_ready,
    output logic [31:0]             spi_req_addr,
    output logic [C_DATA_WIDTH-1:0] spi_req_data
);
    localparam int unsigned CntW = $clog2(C_FIFO_DEPTH) + 1;

    read_state_e             state_q, state_d;
    logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                    arvalid_q, arvalid_d;
    logic [C_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic [31:0]             rem_q, rem_d, spi_base_q, spi_base_d, idx_q, idx_d;
    logic [8:0]              beats_out_q, beats_out_d;
    logic [31:0]             beats, free;
    logic [10:0]             page_words;
    logic                    accept, push, pop, fifo_full, fifo_empty;
    logic [CntW-1:0]         fifo_count;
    logic [C_DATA_WIDTH-1:0] fifo_head;

    assign accept        = start && !busy_q;
    assign m_axi_rready  = (state_q == StData) && !fifo_full;
    assign push          = m_axi_rready && m_axi_rvalid;
    assign spi_req_valid = !fifo_empty;
    assign pop           = spi_req_valid && spi_req_ready;
    assign spi_req_addr  = (spi_base_q + idx_q) << 2;
    assign spi_req_data  = fifo_empty ? '0 : fifo_head;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;

    // Words left before the next 4 KB page; always 1..PageWords for aligned addresses.
    assign page_words = 11'(PageWords) - {1'b0, araddr_q[11:2]};

    always_comb begin
        beats = C_MAX_BURST;
        if (rem_q < beats) beats = rem_q;
        if ({21'd0, page_words} < beats) beats = {21'd0, page_words};
    end

    // Outstanding beats already own FIFO slots, so they count against free space.
    assign free = C_FIFO_DEPTH - 32'(fifo_count) - 32'(beats_out_q);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        rem_d       = rem_q;
        spi_base_d  = spi_base_q;
        idx_d       = idx_q;
        beats_out_d = beats_out_q;

        if (pop) idx_d = idx_q + 32'd1;
        if (done_q) busy_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    araddr_d   = base_addr;
                    rem_d      = word_cnt;
                    spi_base_d = spi_base;
                    idx_d      = '0;
                    state_d    = (word_cnt == '0) ? StFinish : StAddr;
                end
            end
            StAddr: begin
                if (!arvalid_q) begin
                    if (free >= beats) begin
                        arvalid_d = 1'b1;
                        arlen_d   = 8'(beats - 32'd1);
                    end
                end else if (m_axi_arready) begin
                    arvalid_d   = 1'b0;
                    araddr_d    = araddr_q + C_ADDR_WIDTH'(beats * WordBytes);
                    rem_d       = rem_q - beats;
                    beats_out_d = 9'(beats);
                    state_d     = StData;
                end
            end
            StData: begin
                if (push) begin
                    beats_out_d = beats_out_q - 9'd1;
                    // The burst ends on the planned beat count regardless of rlast.
                    if (beats_out_q == 9'd1) begin
                        if (!m_axi_rlast) err_d = 1'b1;
                        state_d = (rem_q != '0) ? StAddr : StWait;
                    end else if (m_axi_rlast) begin
                        err_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (fifo_empty) state_d = StFinish;
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            rem_q       <= '0;
            spi_base_q  <= '0;
            idx_q       <= '0;
            beats_out_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            rem_q       <= rem_d;
            spi_base_q  <= spi_base_d;
            idx_q       <= idx_d;
            beats_out_q <= beats_out_d;
        end
    end

    spi_load_fifo #(
        .Width (C_DATA_WIDTH),
        .Depth (C_FIFO_DEPTH)
    ) u_fifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .push      (push),
        .push_data (m_axi_rdata),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: doc/spi_load_sequencer.md
SPI_LOAD_SEQUENCER -- requirements
Module: spi_load_sequencer

Interface
REQ-001 Parameters: C_ADDR_WIDTH default 64, AXI byte address width; C_DATA_WIDTH default 32, word width (fixed 32); C_MAX_BURST default 16, max beats per read burst; C_FIFO_DEPTH default 32, power of 2, >= C_MAX_BURST.
REQ-002 Ports, clock and reset first; the block has one clock and one reset, and the reset is asynchronous and active-low:
- ap_clk  in  1  sole clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- base_addr  in  C_ADDR_WIDTH  host byte address of the first word; 4-byte aligned.
- word_cnt  in  32  number of 32-bit words to load.
- spi_base  in  32  first SPI target word index.
- busy  out  1  high from the accepted start until the done pulse.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky protocol error flag.
- m_axi_arvalid/arready/araddr/arlen  out/in/out/out  1/1/C_ADDR_WIDTH/8  AXI4 read address channel.
- m_axi_rvalid/rready/rdata/rlast  in/out/in/in  1/1/32/1  AXI4 read data channel.
- spi_req_valid/spi_req_ready  out/in  1/1  write-request handshake to the SPI master.
- spi_req_addr  out  32  SPI byte address = (spi_base + word index) * 4, modulo 2^32.
- spi_req_data  out  32  word to write.

Function
REQ-003 start is sampled only while busy=0; a start pulse while busy=1 is ignored.
REQ-004 On an accepted start, the block latches base_addr, word_cnt and spi_base, and busy rises the next cycle.
REQ-005 Read FSM states:
- IDLE to ADDR on accepted start with word_cnt != 0.
- ADDR: arvalid held high with stable araddr/arlen until arready; then to DATA.
- DATA: returns to ADDR after the rlast beat if words remain to request, otherwise goes to WAIT.
- WAIT: goes to FINISH when the FIFO is empty and no SPI request is pending.
- FINISH: done=1 for one cycle, then IDLE.
REQ-006 Burst beats = min(C_MAX_BURST, remaining words, words left before the next 4 KB boundary of araddr); arlen = beats - 1.
REQ-007 ADDR is entered only when FIFO free entries (free = depth minus occupancy, counting outstanding beats) >= the planned beats; otherwise the FSM stalls in ADDR with arvalid=0.
REQ-008 rready=1 in DATA; each beat is pushed into the FIFO.
REQ-009 araddr advances by beats*4 per burst; the remaining-word counter decrements by beats at AR handshake.
REQ-010 If rlast arrives before the expected last beat, or is missing on the expected last beat, err is set; the burst is treated as complete on the expected beat count, and subsequent transfers proceed.
REQ-011 The SPI side runs independently of the read FSM:
- spi_req_valid = FIFO not empty.
- spi_req_data = FIFO head.
- FIFO pops and the word index increments on valid&&ready.
- spi_req_valid/addr/data stay stable until accepted.
REQ-012 A FIFO push and pop in the same cycle leave occupancy unchanged. Overflow cannot occur because of REQ-007. spi_req_addr wraps modulo 2^32.
REQ-013 With word_cnt=0, an accepted start goes IDLE to FINISH: done pulses 2 cycles after start, and no AXI or SPI traffic is issued.
REQ-014 Latency: arvalid rises 2 cycles after an accepted start. The first spi_req_valid rises 1 cycle after the first rdata beat is accepted.
REQ-015 err clears on an accepted start; otherwise it holds its value.

Reset
REQ-016 Asserting ap_rst_n low asynchronously forces:
- FSM to IDLE and FIFO empty.
- All counters to 0.
- busy, done, err, m_axi_arvalid, m_axi_rready and spi_req_valid to 0.
- araddr, arlen, spi_req_addr and spi_req_data to 0.
REQ-017 Reset asserted mid-load abandons the load: no done pulse is generated, and outstanding AXI beats arriving after deassertion are not accepted (rready=0 in IDLE).
REQ-018 Reset deassertion is synchronous to ap_clk by an external synchronizer; the block adds no synchronizer.

Structure
REQ-019 The shared package spi_load_pkg holds: the read-FSM state enum; the constants for 4 KB page size (4096) and word size in bytes (4); and the C_MAX_BURST and C_FIFO_DEPTH defaults.
REQ-020 The FIFO is one sub-module, spi_load_fifo: a synchronous single-clock FIFO with push/pop/full/empty/count and async active-low reset.

Verification
REQ-021 Scenario 1: base_addr=0x1000, word_cnt=40, spi_base=0, arready/rvalid/spi_req_ready always 1.
- AR bursts: arlen 15, 15, 7 at 0x1000, 0x1040, 0x1080.
- 40 SPI requests with addresses 0x0..0x9C, data in order.
- One done pulse, err=0.
REQ-022 Scenario 2: base_addr=0x1FF8, word_cnt=8.
- Two bursts split at the 4 KB boundary: 0x1FF8 with arlen 1, then 0x2000 with arlen 5.
REQ-023 Scenario 3: word_cnt=0.
- done 2 cycles after start; arvalid and spi_req_valid never assert.
REQ-024 Scenario 4: spi_req_ready=0 for 200 cycles, word_cnt=64.
- At most 2 bursts issued (32 words) before stall; no FIFO overflow.
- All 64 words are delivered after ready returns.
REQ-025 Scenario 5: rlast asserted on beat 3 of a 16-beat burst.
- err=1; load still completes with done; err clears on the next start.
REQ-026 Scenario 6: ap_rst_n pulsed low mid-DATA, and a second start is sent while busy.
- All outputs return to their reset values immediately on reset.
- The start sent while busy is ignored.
